// File: rtl/wb_ram_ctrl.sv
// Wishbone-style slave over an inferred block RAM, with an optional zero-fill after reset.
// ack comes WAIT_STATES+1 edges after stb. A held stb gives one access; dropping stb before ack aborts it.
module wb_ram_ctrl #(
  parameter int AW             = 15,
  parameter int DW             = 16,
  parameter int WAIT_STATES    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk_p,
  input  logic            reset,
  input  logic            stb,
  input  logic            we,
  input  logic [DW/8-1:0] sel,
  input  logic [AW:1]     adr,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o,
  output logic            ack,
  output logic            ready
);

  localparam int NB = DW / 8;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;
  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

  state_t          state, state_nxt;
  logic            ack_reg, ack_nxt, ready_nxt;
  logic [3:0]      wait_cnt, wait_nxt;
  logic [AW-1:0]   clear_cnt, clear_nxt;
  logic            mem_we, rd_en;
  logic [NB-1:0]   mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdat;
  logic [DW-1:0]   mem [0:(1<<AW)-1];

  assign ack = ack_reg & stb;

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    ready_nxt = ready;
    wait_nxt  = wait_cnt;
    clear_nxt = clear_cnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = adr;
    mem_wdat  = dat_i;
    rd_en     = 1'b0;
    case (state)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_be    = '1;
        mem_addr  = clear_cnt;
        mem_wdat  = '0;
        clear_nxt = clear_cnt + AW'(1);
        if (clear_cnt == '1) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end
      end
      S_IDLE: begin
        ready_nxt = 1'b1;
        if (stb && ready) begin
          mem_we = we;
          mem_be = sel;
          rd_en  = !we;
          if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            wait_nxt  = WS_LOAD;
          end else begin
            state_nxt = S_ACK;
            ack_nxt   = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!stb) begin
          state_nxt = S_IDLE;
        end else if (wait_cnt == 4'd0) begin
          state_nxt = S_ACK;
          ack_nxt   = 1'b1;
        end else begin
          wait_nxt = wait_cnt - 4'd1;
        end
      end
      // DONE absorbs a held strobe so the transaction is never repeated
      S_ACK:   state_nxt = stb ? S_DONE : S_IDLE;
      S_DONE:  if (!stb) state_nxt = S_IDLE;
      default: state_nxt = RST_STATE;
    endcase
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk_p) begin
    if (reset) begin
      state     <= RST_STATE;
      ack_reg   <= 1'b0;
      ready     <= 1'b0;
      wait_cnt  <= 4'd0;
      clear_cnt <= '0;
      dat_o     <= '0;
    end else begin
      state     <= state_nxt;
      ack_reg   <= ack_nxt;
      ready     <= ready_nxt;
      wait_cnt  <= wait_nxt;
      clear_cnt <= clear_nxt;
      if (rd_en) dat_o <= mem[adr];
    end
  end

  always_ff @(posedge clk_p) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdat[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_ctrl.sv
// Directed bench for wb_ram_ctrl: three instances (WS=1/clear, WS=0/no clear, WS=3/clear), AW=4, DW=16.
module tb_wb_ram_ctrl;

  logic clk_p = 1'b0;
  always #5 clk_p = ~clk_p;

  logic [2:0]       rst, stb, we, ack, ready;
  logic [2:0][1:0]  sel;
  logic [2:0][3:0]  adr;
  logic [2:0][15:0] dat_i, dat_o;

  int checks = 0;
  int failures = 0;

  wb_ram_ctrl #(.AW(4), .DW(16), .WAIT_STATES(1), .CLEAR_ON_RESET(1)) u_a (
    .clk_p(clk_p), .reset(rst[0]), .stb(stb[0]), .we(we[0]), .sel(sel[0]), .adr(adr[0]),
    .dat_i(dat_i[0]), .dat_o(dat_o[0]), .ack(ack[0]), .ready(ready[0]));
  wb_ram_ctrl #(.AW(4), .DW(16), .WAIT_STATES(0), .CLEAR_ON_RESET(0)) u_b (
    .clk_p(clk_p), .reset(rst[1]), .stb(stb[1]), .we(we[1]), .sel(sel[1]), .adr(adr[1]),
    .dat_i(dat_i[1]), .dat_o(dat_o[1]), .ack(ack[1]), .ready(ready[1]));
  wb_ram_ctrl #(.AW(4), .DW(16), .WAIT_STATES(3), .CLEAR_ON_RESET(1)) u_c (
    .clk_p(clk_p), .reset(rst[2]), .stb(stb[2]), .we(we[2]), .sel(sel[2]), .adr(adr[2]),
    .dat_i(dat_i[2]), .dat_o(dat_o[2]), .ack(ack[2]), .ready(ready[2]));

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic [3:0]  a;
    logic [15:0] d;
    logic [15:0] exp_do;
    int          exp_lat;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic start(input int k, input logic w, input logic [1:0] s,
                       input logic [3:0] a, input logic [15:0] d);
    @(negedge clk_p);
    stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; dat_i[k] = d;
  endtask

  task automatic wait_ack(input int k, output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_p); #1;
      if (ack[k]) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic finish_x(input int k);
    @(negedge clk_p);
    stb[k] = 1'b0; we[k] = 1'b0;
  endtask

  task automatic xact(input int k, input logic w, input logic [1:0] s, input logic [3:0] a,
                      input logic [15:0] d, output int lat, output logic [15:0] rd);
    start(k, w, s, a, d);
    wait_ack(k, lat);
    rd = dat_o[k];
    finish_x(k);
  endtask

  task automatic count_ready(input int k, output int n);
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_p); #1;
      if (ready[k]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, n, acks;
    logic        b_rdy1;
    logic [15:0] rd;

    vt[0]  = '{1'b1, 2'b11, 4'd3,  16'h1234, 16'h0000, 2};
    vt[1]  = '{1'b0, 2'b11, 4'd3,  16'h0000, 16'h1234, 2};
    vt[2]  = '{1'b1, 2'b11, 4'd7,  16'hAAAA, 16'h1234, 2};
    vt[3]  = '{1'b1, 2'b01, 4'd7,  16'h5566, 16'h1234, 2};
    vt[4]  = '{1'b0, 2'b11, 4'd7,  16'h0000, 16'hAA66, 2};
    vt[5]  = '{1'b1, 2'b10, 4'd7,  16'h7700, 16'hAA66, 2};
    vt[6]  = '{1'b0, 2'b11, 4'd7,  16'h0000, 16'h7766, 2};
    vt[7]  = '{1'b0, 2'b00, 4'd3,  16'h0000, 16'h1234, 2};
    vt[8]  = '{1'b1, 2'b11, 4'd15, 16'hFFFF, 16'h1234, 2};
    vt[9]  = '{1'b0, 2'b11, 4'd15, 16'h0000, 16'hFFFF, 2};
    vt[10] = '{1'b0, 2'b11, 4'd0,  16'h0000, 16'h0000, 2};
    vt[11] = '{1'b0, 2'b01, 4'd3,  16'h0000, 16'h1234, 2};

    rst = 3'b111; stb = '0; we = '0; sel = '0; adr = '0; dat_i = '0;
    @(posedge clk_p); #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready%0d", k), ready[k], 0);
      chk($sformatf("rst_ack%0d", k),   ack[k],   0);
      chk($sformatf("rst_dato%0d", k),  dat_o[k], 0);
    end

    // Release all; A holds a read strobe through its clear phase
    @(negedge clk_p);
    rst = 3'b000;
    stb[0] = 1'b1; we[0] = 1'b0; sel[0] = 2'b00; adr[0] = 4'd5;
    n = 0; acks = 0; b_rdy1 = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk_p); #1;
      if (i == 1) b_rdy1 = ready[1];
      if (ack[0]) acks++;
      if (ready[0]) begin
        n = i;
        break;
      end
    end
    chk("clear_cycles", n, 16);
    chk("clear_no_ack", acks, 0);
    chk("noclr_ready_first_edge", b_rdy1, 1);
    wait_ack(0, lat);
    chk("clear_rd5_lat", lat, 2);
    chk("clear_rd5_dat", dat_o[0], 16'h0000);
    finish_x(0);

    for (int i = 0; i < 12; i++) begin
      xact(0, vt[i].w, vt[i].s, vt[i].a, vt[i].d, lat, rd);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_dat", i), rd, vt[i].exp_do);
    end

    // Zero wait states, then a strobe held well past ack with changing write data
    xact(1, 1'b1, 2'b11, 4'd2, 16'h00FF, lat, rd);
    chk("ws0_wr_lat", lat, 1);
    xact(1, 1'b0, 2'b11, 4'd2, 16'h0000, lat, rd);
    chk("ws0_rd_lat", lat, 1);
    chk("ws0_rd_dat", rd, 16'h00FF);
    start(1, 1'b1, 2'b11, 4'd9, 16'h0100);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_p); #1;
      if (ack[1]) acks++;
      @(negedge clk_p);
      dat_i[1] = dat_i[1] + 16'd1;
    end
    chk("hold_single_ack", acks, 1);
    stb[1] = 1'b0; we[1] = 1'b0;
    xact(1, 1'b0, 2'b11, 4'd9, 16'h0000, lat, rd);
    chk("hold_single_write", rd, 16'h0100);

    // Three wait states, then an aborted write
    count_ready(2, n);
    chk("ws3_ready", ready[2], 1);
    xact(2, 1'b1, 2'b11, 4'd1, 16'h4321, lat, rd);
    chk("ws3_wr_lat", lat, 4);
    xact(2, 1'b0, 2'b11, 4'd1, 16'h0000, lat, rd);
    chk("ws3_rd_lat", lat, 4);
    chk("ws3_rd_dat", rd, 16'h4321);
    start(2, 1'b1, 2'b11, 4'd6, 16'hBEEF);
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_p); #1;
      if (ack[2]) acks++;
    end
    @(negedge clk_p);
    stb[2] = 1'b0; we[2] = 1'b0;
    @(posedge clk_p); #1;
    if (ack[2]) acks++;
    chk("abort_no_ack", acks, 0);
    xact(2, 1'b0, 2'b11, 4'd6, 16'h0000, lat, rd);
    chk("after_abort_lat", lat, 4);
    chk("abort_write_kept", rd, 16'hBEEF);

    // Reset A again, then interrupt the clear at word 9
    @(negedge clk_p); rst[0] = 1'b1;
    @(negedge clk_p); rst[0] = 1'b0;
    repeat (9) @(posedge clk_p);
    @(negedge clk_p); rst[0] = 1'b1;
    @(posedge clk_p); #1;
    chk("midclr_ready", ready[0], 0);
    chk("midclr_dato", dat_o[0], 16'h0000);
    @(negedge clk_p); rst[0] = 1'b0;
    count_ready(0, n);
    chk("reclear_cycles", n, 16);
    for (int a = 0; a < 16; a++) begin
      xact(0, 1'b0, 2'b11, 4'(a), 16'h0000, lat, rd);
      chk($sformatf("reclear_w%0d", a), rd, 16'h0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_ram_ctrl.md
Name: wb_ram_ctrl

Overview:
- Parametrised Wishbone-style slave wrapping an inferred on-chip block RAM; successor to the fixed 32K-word RAM and two-flop ack delay used as board main memory.
- Adds configurable address width, data width, wait states, optional zero-fill after reset and a ready flag.
- Sits between the topboard memory port (stb/we/sel/adr/dat/ack/ready) and on-chip memory.

Parameters:
- AW, 15: word-address width; memory depth is 2**AW words; address port is adr[AW:1].
- DW, 16: data width; multiple of 8.
- WAIT_STATES, 1: extra cycles between the access edge and ack; legal range 0..15.
- CLEAR_ON_RESET, 1: 1 = zero-fill all words after reset before ready; 0 = ready one cycle after reset.

Ports:
- clk_p  in  1  processor clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- stb  in  1  transaction strobe; held by the master until ack.
- we  in  1  1 = write, 0 = read; stable while stb is high.
- sel  in  DW/8  byte enables; sel[i] covers dat_i[8i+7:8i].
- adr  in  AW  word address adr[AW:1]; stable while stb is high.
- dat_i  in  DW  write data.
- dat_o  out  DW  read data; valid while ack is high.
- ack  out  1  transaction acknowledge.
- ready  out  1  memory initialised and accepting transactions.

Behaviour:
- Single clock clk_p; reset is synchronous and active-high, sampled on the rising edge of clk_p.
- FSM states: CLEAR, IDLE, WAIT, ACK, DONE.
- Reset values: state = CLEAR if CLEAR_ON_RESET = 1, else IDLE; ready = 0; ack = 0; dat_o = 0; wait counter = 0; clear counter = 0.
- CLEAR:
  - Writes 0 to word clear_cnt, all bytes, one word per cycle; clear_cnt increments.
  - After the word 2**AW-1 write, the next state is IDLE and ready is set.
  - Duration is exactly 2**AW cycles. stb is ignored and ack stays 0.
- With CLEAR_ON_RESET = 0, ready rises on the first edge after reset is released.
- IDLE:
  - On an edge with stb = 1 and ready = 1, the access happens at that edge (edge E0).
  - Write: bytes with sel[i] = 1 are updated; others are untouched.
  - Read: the addressed word is registered into dat_o.
  - Next state is WAIT if WAIT_STATES > 0 (counter loaded with WAIT_STATES-1), else ACK.
- WAIT: the counter decrements each cycle; when it reaches 0, the next state is ACK.
- Latency: ack is registered and asserted in the cycle after edge E0 + WAIT_STATES. With WAIT_STATES = 1, ack is visible 2 cycles after stb was first sampled.
- ACK: ack output = ack_reg AND stb, so a dropped strobe removes ack combinationally. ack_reg is high for exactly one cycle; the next state is DONE.
- DONE: waits for stb = 0, then goes to IDLE. This guarantees one memory access per transaction even if the master holds stb.
  - Back-to-back transactions need at least one stb-low cycle.
- Abort: if stb drops in WAIT or ACK, the FSM goes to IDLE next edge and ack is never seen high. A write already done at E0 stays committed.
- Reads never modify memory; a read with sel = 0 still returns the full word.
- dat_o holds the last read value until the next read; it is not cleared on writes.
- Address is not wrapped or checked; all AW bits are used.
- Reset mid-operation (any state, including CLEAR) restarts from reset values next edge; CLEAR restarts at word 0.
- we and adr are sampled only at E0; later changes are ignored.

Test Plan:
- CLEAR_ON_RESET = 1, AW = 4, reset 1 cycle, stb = 1 from release -> ready = 0 for 16 cycles then 1; no ack during clear; read of addr 5 then returns 0x0000.
- WAIT_STATES = 1: write 0x1234 to addr 3, sel = 11, then read addr 3 -> ack 2 cycles after stb each time; dat_o = 0x1234 with ack.
- Byte lanes: word 7 = 0xAAAA; write 0x5566 with sel = 01 -> reads 0xAA66; then write 0x7700 with sel = 10 -> reads 0x7766.
- WAIT_STATES = 0 and 3 -> ack 1 and 4 cycles after stb respectively; stb held 10 cycles after ack -> single ack pulse and a single write (a counter-pattern write is not repeated).
- Abort: stb dropped in WAIT (WAIT_STATES = 3) -> ack never asserts; next transaction starts normally from IDLE.
- Reset asserted mid-CLEAR at word 9, AW = 4 -> ready stays 0 for 16 cycles after release; all words read back 0.
